// File: rtl/stg_fifo_hs.sv
// stg_fifo_hs: clocked token FIFO between two four-phase return-to-zero
// handshakes. Upstream pushes with Rin/Ain, downstream pops with Rout/Aout.
// Every output comes straight from a register, so there is no combinational
// path from any input to any output. A sticky flag records handshake misuse.
module stg_fifo_hs #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Rin,
  output logic             Ain,
  input  logic [WIDTH-1:0] data_in,
  output logic             Rout,
  input  logic             Aout,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             proto_err
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic {IN_IDLE, IN_ACK} in_st_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_st_t;

  in_st_t           in_st;
  out_st_t          out_st;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             stall;   // Rin was high and refused last edge (FIFO full)
  logic             push, pop;

  // full/empty come from the registered level, so a pop never enables a
  // push on the same edge and a push never enables a load on the same edge.
  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);

  assign push = (in_st == IN_IDLE) && Rin && !full;
  assign pop  = (out_st == OUT_REQ) && Aout;

  // Token storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in;
  end

  // Upstream handshake: accept on request, hold Ain until Rin returns to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_st <= IN_IDLE;
      Ain   <= 1'b0;
    end else begin
      case (in_st)
        IN_IDLE: if (Rin && !full) begin
          Ain   <= 1'b1;
          in_st <= IN_ACK;
        end
        IN_ACK: if (!Rin) begin
          Ain   <= 1'b0;
          in_st <= IN_IDLE;
        end
        default: begin
          Ain   <= 1'b0;
          in_st <= IN_IDLE;
        end
      endcase
    end
  end

  // Downstream handshake: present head token, retire it on Aout, and wait
  // for Aout to return to zero before presenting the next one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_st   <= OUT_IDLE;
      Rout     <= 1'b0;
      data_out <= '0;
      rptr     <= '0;
    end else begin
      case (out_st)
        OUT_IDLE: if (!empty) begin
          data_out <= mem[rptr];
          Rout     <= 1'b1;
          out_st   <= OUT_REQ;
        end
        OUT_REQ: if (Aout) begin
          Rout   <= 1'b0;
          rptr   <= rptr + 1'b1;
          out_st <= OUT_RTZ;
        end
        OUT_RTZ: if (!Aout) begin
          // rptr and level already reflect the retired token here.
          if (!empty) begin
            data_out <= mem[rptr];
            Rout     <= 1'b1;
            out_st   <= OUT_REQ;
          end else begin
            out_st   <= OUT_IDLE;
          end
        end
        default: begin
          Rout   <= 1'b0;
          out_st <= OUT_IDLE;
        end
      endcase
    end
  end

  // Write pointer and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky protocol error: ack with nothing offered, or a refused request
  // withdrawn before it was ever acknowledged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      stall <= (in_st == IN_IDLE) && Rin && full;
      if ((out_st == OUT_IDLE) && Aout)
        proto_err <= 1'b1;
      if ((in_st == IN_IDLE) && !Rin && stall)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stg_fifo_hs.sv
// Directed bench for stg_fifo_hs: reset, single token, fill/backpressure,
// streaming, simultaneous push/pop, request withdrawal, mid-handshake reset
// and spurious downstream acknowledge.
module tb_stg_fifo_hs;
  localparam int WIDTH = 128;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset, Rin, Aout;
  logic             Ain, Rout, full, empty, proto_err;
  logic [WIDTH-1:0] data_in, data_out;
  logic [AW:0]      level;

  int n_chk  = 0;
  int n_pass = 0;

  stg_fifo_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Rin(Rin), .Ain(Ain), .data_in(data_in),
    .Rout(Rout), .Aout(Aout), .data_out(data_out), .level(level),
    .full(full), .empty(empty), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full upstream four-phase cycle for one token.
  task automatic up_send(input logic [WIDTH-1:0] d, output bit ok);
    ok = 1'b0; Rin = 1'b1; data_in = d;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (Ain) begin ok = 1'b1; break; end
    end
    Rin = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
        tick();
        if (!Ain) begin ok = 1'b1; break; end
      end
    end
  endtask

  // Full downstream four-phase cycle for one token.
  task automatic dn_recv(output logic [WIDTH-1:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 64; i++) begin
      if (Rout) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      d = data_out; Aout = 1'b1; ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
        tick();
        if (!Rout) begin ok = 1'b1; break; end
      end
      Aout = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; Rin = 1'b0; Aout = 1'b0; data_in = '0;
    tick(); tick();
    n_chk++; if ({Ain, Rout, full, empty, proto_err} !== 5'b00010)
      $display("FAIL reset_flags got %b exp 00010", {Ain, Rout, full, empty, proto_err}); else n_pass++;
    n_chk++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else n_pass++;
    n_chk++; if (data_out !== '0) $display("FAIL reset_data got %h exp 0", data_out); else n_pass++;
    reset = 1'b1; tick();
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] pat;
    pat = {4{32'hA5A5A5A5}};
    Rin = 1'b1; data_in = pat;
    tick();
    n_chk++; if ({Ain, Rout} !== 2'b10) $display("FAIL single_ack got Ain/Rout %b exp 10", {Ain, Rout}); else n_pass++;
    n_chk++; if (level !== 3'd1) $display("FAIL single_level got %0d exp 1", level); else n_pass++;
    Rin = 1'b0;
    tick();
    n_chk++; if ({Ain, Rout} !== 2'b01) $display("FAIL single_req got Ain/Rout %b exp 01", {Ain, Rout}); else n_pass++;
    n_chk++; if (data_out !== pat) $display("FAIL single_data got %h exp %h", data_out, pat); else n_pass++;
    Aout = 1'b1;
    tick();
    n_chk++; if ({Rout, empty} !== 2'b01 || level !== 3'd0)
      $display("FAIL single_pop got Rout/empty %b level %0d exp 01 level 0", {Rout, empty}, level); else n_pass++;
    Aout = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    bit ok, all_ok;
    logic [WIDTH-1:0] got;
    all_ok = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_send(WIDTH'(i), ok);
      all_ok &= ok;
    end
    n_chk++; if (!all_ok) $display("FAIL fill_push got timeout exp 4 accepted"); else n_pass++;
    n_chk++; if (level !== 3'd4 || full !== 1'b1)
      $display("FAIL fill_full got level %0d full %b exp 4 1", level, full); else n_pass++;
    n_chk++; if (Rout !== 1'b1 || data_out !== WIDTH'(1))
      $display("FAIL fill_head got Rout %b data %h exp 1 1", Rout, data_out); else n_pass++;
    Rin = 1'b1; data_in = WIDTH'(5);
    tick(); tick(); tick();
    n_chk++; if (Ain !== 1'b0 || level !== 3'd4)
      $display("FAIL fill_block got Ain %b level %0d exp 0 4", Ain, level); else n_pass++;
    Aout = 1'b1;
    tick();
    n_chk++; if (Ain !== 1'b0 || level !== 3'd3)
      $display("FAIL fill_popedge got Ain %b level %0d exp 0 3", Ain, level); else n_pass++;
    Aout = 1'b0;
    tick();
    n_chk++; if (Ain !== 1'b1 || level !== 3'd4)
      $display("FAIL fill_late_push got Ain %b level %0d exp 1 4", Ain, level); else n_pass++;
    Rin = 1'b0;
    tick();
    for (int e = 2; e <= 5; e++) begin
      dn_recv(got, ok);
      n_chk++; if (!ok || got !== WIDTH'(e))
        $display("FAIL fill_order got %h ok %b exp %h", got, ok, WIDTH'(e)); else n_pass++;
    end
    n_chk++; if (empty !== 1'b1) $display("FAIL fill_empty got %b exp 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok_u, ok_d, done, up_bad;
    int maxlvl, bad;
    logic [WIDTH-1:0] got;
    done = 1'b0; maxlvl = 0; bad = 0; up_bad = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          up_send(WIDTH'(32'h100 + i), ok_u);
          if (!ok_u) up_bad = 1'b1;
        end
      end
      begin
        for (int i = 0; i < 16; i++) begin
          dn_recv(got, ok_d);
          if (!ok_d || got !== WIDTH'(32'h100 + i)) begin
            bad++;
            $display("FAIL stream_tok%0d got %h exp %h", i, got, WIDTH'(32'h100 + i));
          end
        end
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !done; c++) begin
          tick();
          if (int'(level) > maxlvl) maxlvl = int'(level);
        end
      end
    join
    n_chk++; if (bad != 0 || up_bad) $display("FAIL stream_order got %0d bad tokens exp 0", bad); else n_pass++;
    n_chk++; if (maxlvl > 2) $display("FAIL stream_level got max %0d exp <=2", maxlvl); else n_pass++;
    n_chk++; if (proto_err !== 1'b0 || empty !== 1'b1)
      $display("FAIL stream_end got err %b empty %b exp 0 1", proto_err, empty); else n_pass++;
    tick();
  endtask

  task automatic test_simul();
    bit ok;
    logic [WIDTH-1:0] got;
    up_send(WIDTH'(32'hA1), ok);
    up_send(WIDTH'(32'hB2), ok);
    n_chk++; if (level !== 3'd2 || Rout !== 1'b1 || data_out !== WIDTH'(32'hA1))
      $display("FAIL simul_setup got level %0d Rout %b data %h exp 2 1 a1", level, Rout, data_out); else n_pass++;
    Rin = 1'b1; data_in = WIDTH'(32'hC3); Aout = 1'b1;
    tick();
    n_chk++; if (level !== 3'd2 || Ain !== 1'b1 || Rout !== 1'b0)
      $display("FAIL simul_level got level %0d Ain %b Rout %b exp 2 1 0", level, Ain, Rout); else n_pass++;
    Rin = 1'b0; Aout = 1'b0;
    tick();
    dn_recv(got, ok);
    n_chk++; if (!ok || got !== WIDTH'(32'hB2)) $display("FAIL simul_first got %h exp b2", got); else n_pass++;
    dn_recv(got, ok);
    n_chk++; if (!ok || got !== WIDTH'(32'hC3)) $display("FAIL simul_second got %h exp c3", got); else n_pass++;
  endtask

  task automatic test_withdraw();
    bit ok;
    for (int i = 0; i < 4; i++) up_send(WIDTH'(32'hD0 + i), ok);
    Rin = 1'b1; data_in = WIDTH'(32'hEE);
    tick();
    n_chk++; if (Ain !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL withdraw_stall got Ain %b err %b exp 0 0", Ain, proto_err); else n_pass++;
    Rin = 1'b0;
    tick();
    n_chk++; if (proto_err !== 1'b1 || level !== 3'd4)
      $display("FAIL withdraw_err got err %b level %0d exp 1 4", proto_err, level); else n_pass++;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    n_chk++; if (proto_err !== 1'b0 || level !== 3'd0)
      $display("FAIL withdraw_clear got err %b level %0d exp 0 0", proto_err, level); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [WIDTH-1:0] got;
    up_send(WIDTH'(32'h77), ok);
    Rin = 1'b1; data_in = WIDTH'(32'h88);
    tick();
    n_chk++; if ({Ain, Rout} !== 2'b11) $display("FAIL rmid_setup got Ain/Rout %b exp 11", {Ain, Rout}); else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++; if ({Ain, Rout} !== 2'b00 || level !== 3'd0 || data_out !== '0)
      $display("FAIL rmid_clear got Ain/Rout %b level %0d data %h exp 00 0 0", {Ain, Rout}, level, data_out); else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++; if (Ain !== 1'b1 || level !== 3'd1)
      $display("FAIL rmid_fresh got Ain %b level %0d exp 1 1", Ain, level); else n_pass++;
    Rin = 1'b0;
    tick();
    dn_recv(got, ok);
    n_chk++; if (!ok || got !== WIDTH'(32'h88)) $display("FAIL rmid_token got %h exp 88", got); else n_pass++;
  endtask

  task automatic test_proto_err();
    bit ok;
    logic [WIDTH-1:0] got;
    tick();
    n_chk++; if (proto_err !== 1'b0) $display("FAIL perr_pre got %b exp 0", proto_err); else n_pass++;
    Aout = 1'b1;
    tick();
    n_chk++; if (proto_err !== 1'b1 || Rout !== 1'b0)
      $display("FAIL perr_set got err %b Rout %b exp 1 0", proto_err, Rout); else n_pass++;
    Aout = 1'b0;
    up_send(WIDTH'(32'h5A), ok);
    dn_recv(got, ok);
    n_chk++; if (!ok || got !== WIDTH'(32'h5A) || proto_err !== 1'b1)
      $display("FAIL perr_sticky got data %h err %b exp 5a 1", got, proto_err); else n_pass++;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    n_chk++; if (proto_err !== 1'b0) $display("FAIL perr_clear got %b exp 0", proto_err); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; Rin = 1'b0; Aout = 1'b0; data_in = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_simul();
    test_withdraw();
    test_reset_mid();
    test_proto_err();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
